mem_arbiter: RTL and testbench

Single-port memory arbiter that shares the CPU's unified word-addressed memory between three requesters: instruction fetch, load/store data, and a program-loader/debug port. It sits between the CPU core and the memory array. Every cycle it grants at most one access and steers the 1-cycle-latency read/ack response back to the granted requester. Loader has fixed top priority; fetch and data alternate round-robin.

---
 rtl/mem_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Single-port memory arbiter. It shares one word-addressed memory
//            between instruction fetch, load/store data and a program-loader
//            / debug port. At most one access is granted per cycle. The
//            1-cycle read/ack response is steered back to the requester that
//            was granted.
//            Priority: loader first, then fetch/data in round-robin order.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   MEM_ARB_LOADER_EN  defined   -> loader port is functional.
//                      undefined -> ld_* inputs are ignored, ld_* outputs are
//                                   tied 0, and arbitration is IF/D only.
// ----------------------------------------------------------------------------
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   if_req/if_addr                  fetch read request
//   if_gnt                          fetch request accepted this cycle
//   if_rvalid/if_rdata/if_err       fetch response (1 cycle after gnt)
//   d_req/d_we/d_be/d_addr/d_wdata  data request (d_be = byte write mask)
//   d_gnt                           data request accepted this cycle
//   d_rvalid/d_rdata/d_err          data response
//   ld_req/ld_we/ld_addr/ld_wdata   loader request (full-word writes only)
//   ld_gnt                          loader request accepted this cycle
//   ld_rvalid/ld_rdata/ld_err       loader response
//   mem_en/mem_we/mem_be/
//   mem_addr/mem_wdata              memory command
//   mem_rdata                       memory read data, valid the cycle after
//                                   a read command
// ============================================================================
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_WORDS  = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  // instruction fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WIDTH-1:0]      if_rdata,
  output logic                  if_err,
  // load/store data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0]      d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WIDTH-1:0]      d_rdata,
  output logic                  d_err,
  // program loader / debug port
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [WIDTH-1:0]      ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [WIDTH-1:0]      ld_rdata,
  output logic                  ld_err,
  // memory command / response
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata
);

  // Response owner encoding
  localparam logic [1:0] c_own_if = 2'd0;
  localparam logic [1:0] c_own_d  = 2'd1;
  localparam logic [1:0] c_own_ld = 2'd2;

  // Round-robin history: last fetch/data winner
  localparam logic c_rr_if = 1'b0;
  localparam logic c_rr_d  = 1'b1;

  // One extra bit so that MEM_WORDS == 2**ADDR_WIDTH is representable
  localparam logic [ADDR_WIDTH:0] c_mem_words = (ADDR_WIDTH+1)'(MEM_WORDS);

  logic                  r_rr_last;
  logic                  r_resp_valid;
  logic [1:0]            r_resp_owner;
  logic                  r_resp_err;
  logic                  r_resp_wr;

  logic                  w_ld_req;
  logic                  w_ld_gnt;
  logic                  w_if_gnt;
  logic                  w_d_gnt;
  logic                  w_any_gnt;

  logic                  w_if_oor;
  logic                  w_d_oor;
  logic                  w_ld_oor;

  logic                  w_sel_we;
  logic [3:0]            w_sel_be;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [WIDTH-1:0]      w_sel_wdata;
  logic                  w_sel_oor;
  logic [1:0]            w_sel_owner;

  logic [WIDTH-1:0]      w_rsp_rdata;

  // --------------------------------------------------------------------------
  // Loader enable
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_LOADER_EN
  assign w_ld_req = ld_req;
`else
  // Loader port stays in the interface but never requests.
  logic w_unused_ld;
  assign w_ld_req    = 1'b0;
  assign w_unused_ld = ld_req;
`endif

  // --------------------------------------------------------------------------
  // Out-of-range detection
  // --------------------------------------------------------------------------
  assign w_if_oor = ({1'b0, if_addr} >= c_mem_words);
  assign w_d_oor  = ({1'b0, d_addr}  >= c_mem_words);
  assign w_ld_oor = ({1'b0, ld_addr} >= c_mem_words);

  // --------------------------------------------------------------------------
  // Grant selection (same cycle). Grants are forced low while in reset.
  // On a fetch/data tie, the port that did not win last time gets the grant.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ld_gnt = rstn & w_ld_req;
    w_if_gnt = rstn & ~w_ld_req & if_req & (~d_req  | (r_rr_last == c_rr_d));
    w_d_gnt  = rstn & ~w_ld_req & d_req  & (~if_req | (r_rr_last == c_rr_if));
  end

  assign w_any_gnt = w_ld_gnt | w_if_gnt | w_d_gnt;

  // --------------------------------------------------------------------------
  // Command mux from the winner
  // --------------------------------------------------------------------------
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_be    = 4'h0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_oor   = 1'b0;
    w_sel_owner = c_own_if;
    if (w_ld_gnt) begin
      w_sel_we    = ld_we;
      w_sel_be    = 4'hF;
      w_sel_addr  = ld_addr;
      w_sel_wdata = ld_wdata;
      w_sel_oor   = w_ld_oor;
      w_sel_owner = c_own_ld;
    end else if (w_d_gnt) begin
      w_sel_we    = d_we;
      w_sel_be    = d_be;
      w_sel_addr  = d_addr;
      w_sel_wdata = d_wdata;
      w_sel_oor   = w_d_oor;
      w_sel_owner = c_own_d;
    end else if (w_if_gnt) begin
      // Fetch is read-only, full word
      w_sel_we    = 1'b0;
      w_sel_be    = 4'hF;
      w_sel_addr  = if_addr;
      w_sel_wdata = '0;
      w_sel_oor   = w_if_oor;
      w_sel_owner = c_own_if;
    end
  end

  // An out-of-range access is still granted and acked, but it never reaches
  // the memory.
  assign mem_en    = w_any_gnt & ~w_sel_oor;
  assign mem_we    = w_sel_we;
  assign mem_be    = w_sel_be;
  assign mem_addr  = w_sel_addr;
  assign mem_wdata = w_sel_wdata;

  // --------------------------------------------------------------------------
  // Response tracking and round-robin history
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_resp_valid <= 1'b0;
      r_resp_owner <= c_own_if;
      r_resp_err   <= 1'b0;
      r_resp_wr    <= 1'b0;
      r_rr_last    <= c_rr_if;
    end else begin
      r_resp_valid <= w_any_gnt;
      if (w_any_gnt) begin
        r_resp_owner <= w_sel_owner;
        r_resp_err   <= w_sel_oor;
        r_resp_wr    <= w_sel_we;
      end
      // Loader grants leave the fetch/data history untouched
      if (w_if_gnt) begin
        r_rr_last <= c_rr_if;
      end else if (w_d_gnt) begin
        r_rr_last <= c_rr_d;
      end
    end
  end

  // Write acks and error responses return zero data
  assign w_rsp_rdata = (r_resp_err | r_resp_wr) ? '0 : mem_rdata;

  // --------------------------------------------------------------------------
  // Response steering
  // --------------------------------------------------------------------------
  assign if_gnt    = w_if_gnt;
  assign if_rvalid = r_resp_valid & (r_resp_owner == c_own_if);
  assign if_rdata  = if_rvalid ? w_rsp_rdata : '0;
  assign if_err    = if_rvalid & r_resp_err;

  assign d_gnt     = w_d_gnt;
  assign d_rvalid  = r_resp_valid & (r_resp_owner == c_own_d);
  assign d_rdata   = d_rvalid ? w_rsp_rdata : '0;
  assign d_err     = d_rvalid & r_resp_err;

`ifdef MEM_ARB_LOADER_EN
  assign ld_gnt    = w_ld_gnt;
  assign ld_rvalid = r_resp_valid & (r_resp_owner == c_own_ld);
  assign ld_rdata  = ld_rvalid ? w_rsp_rdata : '0;
  assign ld_err    = ld_rvalid & r_resp_err;
`else
  logic w_unused_ld_gnt;
  assign w_unused_ld_gnt = w_ld_gnt;
  assign ld_gnt    = 1'b0;
  assign ld_rvalid = 1'b0;
  assign ld_rdata  = '0;
  assign ld_err    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. A behavioural
//            memory with byte lanes and 1-cycle read latency is attached.
//            MEM_WORDS is set to 4000 so that the top of the address space
//            is out of range.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int WIDTH = 32;
  localparam int AW    = 12;
  localparam int WORDS = 4000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid, if_err;
  logic [31:0]   if_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt, d_rvalid, d_err;
  logic [31:0]   d_rdata;
  logic          ld_req, ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt, ld_rvalid, ld_err;
  logic [31:0]   ld_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .MEM_WORDS(WORDS)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory, preloaded on the first clock edge
  logic [31:0] mem [0:4095];
  logic        mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
      mem[12'h010] <= 32'h03C000EF;
      mem[12'h020] <= 32'h11223344;
      mem[12'hF9F] <= 32'hCAFEF00D;
      mem_loaded   <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // winner codes: 1=IF 2=D 3=LD
  int seq [4];
  int prev;

  initial begin
    rstn = 1'b0;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    tick(); tick();

    // ---- reset state; grants forced low in reset ----
    chk("rst_if_rvalid", if_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_ld_rvalid", ld_rvalid, 1'b0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    if_req = 1; if_addr = 12'h010;
    #1;
    chk("rst_if_gnt", if_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);

    // ---- release reset, held fetch is granted ----
    rstn = 1'b1;
    #1;
    chk("f_if_gnt", if_gnt, 1'b1);
    chk("f_d_gnt", d_gnt, 1'b0);
    chk("f_mem_en", mem_en, 1'b1);
    chk("f_mem_addr", mem_addr, 32'h010);
    chk("f_mem_be", mem_be, 32'hF);
    chk("f_mem_we", mem_we, 1'b0);
    tick();
    if_req = 0;
    chk("f_if_rvalid", if_rvalid, 1'b1);
    chk("f_if_rdata", if_rdata, 32'h03C000EF);
    chk("f_if_err", if_err, 1'b0);
    chk("f_d_rvalid", d_rvalid, 1'b0);

    // ---- IF/D tie, rr_last=IF: D, IF, D, IF ----
    if_req = 1; if_addr = 12'h010;
    d_req = 1; d_we = 0; d_addr = 12'h020;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_if_gnt", if_gnt, (i % 2) == 1);
      chk("rr_d_gnt", d_gnt, (i % 2) == 0);
      tick();
      chk("rr_if_rvalid", if_rvalid, (i % 2) == 1);
      chk("rr_d_rvalid", d_rvalid, (i % 2) == 0);
      chk("rr_if_rdata", if_rdata, ((i % 2) == 1) ? 32'h03C000EF : 32'h0);
      chk("rr_d_rdata", d_rdata, ((i % 2) == 0) ? 32'h11223344 : 32'h0);
    end
    if_req = 0; d_req = 0;

    // ---- partial write, then readback merge ----
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 12'h020; d_wdata = 32'hAABBCCDD;
    #1;
    chk("w_d_gnt", d_gnt, 1'b1);
    chk("w_mem_en", mem_en, 1'b1);
    chk("w_mem_we", mem_we, 1'b1);
    chk("w_mem_be", mem_be, 32'h3);
    chk("w_mem_wdata", mem_wdata, 32'hAABBCCDD);
    tick();
    chk("w_d_rvalid", d_rvalid, 1'b1);
    chk("w_d_rdata", d_rdata, 32'h0);
    d_we = 0; d_be = 4'h0;
    #1;
    chk("rb_d_gnt", d_gnt, 1'b1);
    tick();
    chk("rb_d_rvalid", d_rvalid, 1'b1);
    chk("rb_d_rdata", d_rdata, 32'h1122CCDD);

    // ---- zero-mask write: legal no-op ----
    d_we = 1; d_be = 4'h0; d_wdata = 32'hFFFFFFFF;
    #1;
    chk("nop_d_gnt", d_gnt, 1'b1);
    chk("nop_mem_en", mem_en, 1'b1);
    chk("nop_mem_be", mem_be, 32'h0);
    tick();
    chk("nop_d_rvalid", d_rvalid, 1'b1);
    d_req = 0; d_we = 0;
    // rr_last is now D

    // ---- loader plus IF plus D held 3 cycles, then loader drops ----
`ifdef MEM_ARB_LOADER_EN
    seq[0] = 3; seq[1] = 3; seq[2] = 3; seq[3] = 1;
`else
    seq[0] = 1; seq[1] = 2; seq[2] = 1; seq[3] = 2;
`endif
    ld_req = 1; ld_we = 0; ld_addr = 12'h010;
    if_req = 1; if_addr = 12'h010;
    d_req = 1; d_we = 0; d_addr = 12'h020;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ld_req = 0;
      #1;
      chk("ld_if_gnt", if_gnt, seq[i] == 1);
      chk("ld_d_gnt", d_gnt, seq[i] == 2);
      chk("ld_ld_gnt", ld_gnt, seq[i] == 3);
      tick();
      prev = seq[i];
      chk("ld_if_rvalid", if_rvalid, prev == 1);
      chk("ld_d_rvalid", d_rvalid, prev == 2);
      chk("ld_ld_rvalid", ld_rvalid, prev == 3);
      chk("ld_ld_rdata", ld_rdata, (prev == 3) ? 32'h03C000EF : 32'h0);
    end
    if_req = 0; d_req = 0;

    // ---- loader write (full word) / ignored when disabled ----
    ld_req = 1; ld_we = 1; ld_addr = 12'h030; ld_wdata = 32'hDEADBEEF;
    #1;
`ifdef MEM_ARB_LOADER_EN
    chk("ldw_ld_gnt", ld_gnt, 1'b1);
    chk("ldw_mem_be", mem_be, 32'hF);
    chk("ldw_mem_en", mem_en, 1'b1);
    tick();
    chk("ldw_ld_rvalid", ld_rvalid, 1'b1);
    chk("ldw_ld_rdata", ld_rdata, 32'h0);
`else
    chk("ldw_ld_gnt", ld_gnt, 1'b0);
    chk("ldw_mem_en", mem_en, 1'b0);
    tick();
    chk("ldw_ld_rvalid", ld_rvalid, 1'b0);
`endif
    ld_req = 0; ld_we = 0;

    // ---- out-of-range and boundary addresses ----
    if_req = 1; if_addr = 12'hFA0;
    #1;
    chk("oor_if_gnt", if_gnt, 1'b1);
    chk("oor_if_mem_en", mem_en, 1'b0);
    tick();
    if_req = 0;
    chk("oor_if_rvalid", if_rvalid, 1'b1);
    chk("oor_if_err", if_err, 1'b1);
    chk("oor_if_rdata", if_rdata, 32'h0);

    d_req = 1; d_we = 0; d_addr = 12'hFFF;
    #1;
    chk("oor_d_gnt", d_gnt, 1'b1);
    chk("oor_d_mem_en", mem_en, 1'b0);
    tick();
    chk("oor_d_rvalid", d_rvalid, 1'b1);
    chk("oor_d_err", d_err, 1'b1);
    chk("oor_d_rdata", d_rdata, 32'h0);

    d_addr = 12'hF9F;  // last valid word
    #1;
    chk("edge_lo_mem_en", mem_en, 1'b1);
    tick();
    chk("edge_lo_err", d_err, 1'b0);
    chk("edge_lo_rdata", d_rdata, 32'hCAFEF00D);

    d_addr = 12'hFA0;  // first invalid word
    #1;
    chk("edge_hi_mem_en", mem_en, 1'b0);
    tick();
    chk("edge_hi_err", d_err, 1'b1);
    d_req = 0;
    // rr_last is now D

    // ---- reset while a grant is in flight ----
    if_req = 1; if_addr = 12'h010;
    #1;
    chk("mr_if_gnt", if_gnt, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mr_if_gnt_rst", if_gnt, 1'b0);
    tick();
    chk("mr_if_rvalid", if_rvalid, 1'b0);
    chk("mr_d_rvalid", d_rvalid, 1'b0);
    rstn = 1'b1;
    d_req = 1; d_we = 0; d_addr = 12'h020;
    #1;
    // rr_last back to IF, so D wins this tie
    chk("mr_tie_d_gnt", d_gnt, 1'b1);
    chk("mr_tie_if_gnt", if_gnt, 1'b0);
    tick();
    chk("mr_d_rvalid2", d_rvalid, 1'b1);
    chk("mr_d_rdata2", d_rdata, 32'h1122CCDD);
    #1;
    chk("mr_held_if_gnt", if_gnt, 1'b1);
    tick();
    if_req = 0; d_req = 0;
    chk("mr_if_rvalid2", if_rvalid, 1'b1);
    chk("mr_if_rdata2", if_rdata, 32'h03C000EF);
    tick();
    chk("idle_if_rvalid", if_rvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
